// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus, stall encodings,
// FSM states and the default watchdog redirect vector.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int WDOG_W  = 8;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam logic STOP     = 1'b1;
  localparam logic NOT_STOP = 1'b0;

  // Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
  localparam stall_bus_t STALL_FLUSH = {6{STOP}};
  localparam stall_bus_t STALL_MEM   = {NOT_STOP, {5{STOP}}};
  localparam stall_bus_t STALL_EX    = {{2{NOT_STOP}}, {4{STOP}}};
  localparam stall_bus_t STALL_ID    = {{3{NOT_STOP}}, {3{STOP}}};
  localparam stall_bus_t STALL_NONE  = {6{NOT_STOP}};

  localparam logic [31:0] TIMEOUT_VEC_DEF = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01
  } state_t;

  function automatic stall_bus_t stall_encode(input logic flush, input logic mem,
                                              input logic ex, input logic id);
    if (flush)    return STALL_FLUSH;
    else if (mem) return STALL_MEM;
    else if (ex)  return STALL_EX;
    else if (id)  return STALL_ID;
    else          return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the controller.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        flush_req;
  logic [31:0] exc_pc_i;
  stall_bus_t  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        timeout_o;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, flush_req, exc_pc_i,
    input  stall_o, flush_o, new_pc_o, timeout_o
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, flush_req, exc_pc_i,
    output stall_o, flush_o, new_pc_o, timeout_o
  );
endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Memory-stall watchdog: counts consecutive inc cycles and pulses expire on
// the cycle the count reaches WAIT_LIMIT, clearing itself at the same edge.
module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expire
);

  localparam logic [WDOG_W:0] LIMIT = WAIT_LIMIT[WDOG_W:0];
  localparam logic [WDOG_W:0] ONE   = {{WDOG_W{1'b0}}, 1'b1};

  logic [WDOG_W-1:0] count;
  logic [WDOG_W:0]   count_inc;

  assign count_inc = {1'b0, count} + ONE;
  assign expire    = inc && !clr && (count_inc >= LIMIT);

  // Saturate rather than wrap, even though expiry normally clears first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || expire) begin
      count <= '0;
    end else if (inc) begin
      count <= (count_inc >= LIMIT) ? LIMIT[WDOG_W-1:0] : count_inc[WDOG_W-1:0];
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with optional memory-stall watchdog,
// built only when PIPE_CTRL_WDOG_EN is defined.
//
// state    | meaning
// ST_RUN   | normal operation, stall bus follows requests by priority
// ST_FLUSH | one-cycle flush pulse, new_pc_o holds the redirect target
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          WAIT_LIMIT  = 255,
  parameter logic [31:0] TIMEOUT_VEC = TIMEOUT_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_limit_chk
    $error("pipe_ctrl: WAIT_LIMIT must be within 1..255");
  end

  state_t      state;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic        expire;
  stall_bus_t  stall_d;

`ifdef PIPE_CTRL_WDOG_EN
  logic wdog_inc;

  assign wdog_inc = (state == ST_RUN) && bus.stallreq_mem && !bus.flush_req;

  pipe_ctrl_wdog #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .inc    (wdog_inc),
    .clr    (!wdog_inc),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.flush_req) begin
            state    <= ST_FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= bus.exc_pc_i;
          end else if (expire) begin
            state    <= ST_FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= TIMEOUT_VEC;
          end else begin
            flush_q  <= 1'b0;
            new_pc_q <= '0;
          end
        end
        default: begin
          state    <= ST_RUN;
          flush_q  <= 1'b0;
          new_pc_q <= '0;
        end
      endcase
    end
  end

  // Reset forces the stall bus quiet even while requests are still asserted
  always_comb begin
    stall_d = STALL_NONE;
    if (rst && state == ST_RUN) begin
      stall_d = stall_encode(bus.flush_req, bus.stallreq_mem,
                             bus.stallreq_ex, bus.stallreq_id);
    end
  end

  assign bus.stall_o   = stall_d;
  assign bus.flush_o   = flush_q;
  assign bus.new_pc_o  = new_pc_q;
  assign bus.timeout_o = rst && expire;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: priority table, directed multi-cycle
// sequences and randomized traffic against a streak-counting reference model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int          LIMIT = 4;
  localparam logic [31:0] TV    = 32'hBFC0_0380;
`ifdef PIPE_CTRL_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  pipe_ctrl_if bus();

  pipe_ctrl #(
    .WAIT_LIMIT  (LIMIT),
    .TIMEOUT_VEC (TV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       id;
    logic       ex;
    logic       mem;
    logic       fl;
    logic [5:0] exp_stall;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [5:0] st, input logic fo,
                      input logic [31:0] pc, input logic to);
    check({tag, ".stall"},   32'(bus.stall_o),   32'(st));
    check({tag, ".flush"},   32'(bus.flush_o),   32'(fo));
    check({tag, ".new_pc"},  bus.new_pc_o,       pc);
    check({tag, ".timeout"}, 32'(bus.timeout_o), 32'(to));
  endtask

  task automatic drive(input logic id, input logic ex, input logic mem,
                       input logic fl, input logic [31:0] pc);
    bus.stallreq_id  = id;
    bus.stallreq_ex  = ex;
    bus.stallreq_mem = mem;
    bus.flush_req    = fl;
    bus.exc_pc_i     = pc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL time_limit: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic        m_flush;
    logic [31:0] m_pc;
    int          m_streak;
    logic        id, ex, mem, fl, exp_to;
    logic [31:0] pc;
    logic [5:0]  exp_st;

    tbl[0] = '{0, 0, 0, 0, 6'b000000};
    tbl[1] = '{1, 0, 0, 0, 6'b000111};
    tbl[2] = '{0, 1, 0, 0, 6'b001111};
    tbl[3] = '{1, 1, 0, 0, 6'b001111};
    tbl[4] = '{0, 0, 1, 0, 6'b011111};
    tbl[5] = '{1, 0, 1, 0, 6'b011111};
    tbl[6] = '{1, 1, 1, 0, 6'b011111};
    tbl[7] = '{1, 1, 1, 1, 6'b111111};
    tbl[8] = '{0, 0, 0, 1, 6'b111111};

    // Reset with all requests asserted: everything must read zero
    rst = 1'b0;
    drive(1, 1, 1, 1, 32'hFFFF_FFFF);
    #1;
    outs("reset", 6'b000000, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    idle(2);

    // Priority table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(tbl[i].id, tbl[i].ex, tbl[i].mem, tbl[i].fl, 32'h1000 + 32'(i));
      #1;
      check($sformatf("tbl%0d.stall", i), 32'(bus.stall_o), 32'(tbl[i].exp_stall));
      @(negedge clk);
      drive(0, 0, 0, 0, 32'h0);
      #1;
      check($sformatf("tbl%0d.flush", i), 32'(bus.flush_o), 32'(tbl[i].fl));
      check($sformatf("tbl%0d.new_pc", i), bus.new_pc_o, tbl[i].fl ? 32'h1000 + 32'(i) : 32'h0);
      idle(1);
    end

    // Requests stacking up in the same cycle
    @(negedge clk); drive(1, 0, 0, 0, 0); #1; outs("stack_id",  6'b000111, 0, 0, 0);
    @(negedge clk); drive(1, 1, 0, 0, 0); #1; outs("stack_ex",  6'b001111, 0, 0, 0);
    @(negedge clk); drive(1, 1, 1, 0, 0); #1; outs("stack_mem", 6'b011111, 0, 0, 0);
    idle(2);

    // Single flush request
    @(negedge clk); drive(0, 0, 0, 1, 32'h8000_0180); #1;
    outs("flush_c0", 6'b111111, 0, 32'h0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0); #1;
    outs("flush_c1", 6'b000000, 1, 32'h8000_0180, 0);
    @(negedge clk); #1;
    outs("flush_c2", 6'b000000, 0, 32'h0, 0);
    idle(1);

    // Memory stall held long enough to reach the watchdog limit
    for (int i = 1; i <= LIMIT; i++) begin
      @(negedge clk); drive(0, 0, 1, 0, 0); #1;
      outs($sformatf("wdog_c%0d", i), 6'b011111, 0, 32'h0, WDOG && (i == LIMIT));
    end
    @(negedge clk); #1;
    outs("wdog_redirect", WDOG ? 6'b000000 : 6'b011111, WDOG, WDOG ? TV : 32'h0, 0);
    idle(2);

    // Stall streak interrupted by one idle cycle never expires
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); drive(0, 0, (i != 3), 0, 0); #1;
      check($sformatf("gap_c%0d.timeout", i), 32'(bus.timeout_o), 32'h0);
      check($sformatf("gap_c%0d.flush", i), 32'(bus.flush_o), 32'h0);
    end
    idle(2);

    // Flush request on the cycle the watchdog would expire
    for (int i = 1; i < LIMIT; i++) begin
      @(negedge clk); drive(0, 0, 1, 0, 0);
    end
    @(negedge clk); drive(0, 0, 1, 1, 32'h1234_5670); #1;
    outs("coinc_c0", 6'b111111, 0, 32'h0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0); #1;
    outs("coinc_c1", 6'b000000, 1, 32'h1234_5670, 0);
    @(negedge clk); #1;
    outs("coinc_c2", 6'b000000, 0, 32'h0, 0);
    idle(1);

    // Reset pulled low in the middle of a flush pulse
    @(negedge clk); drive(0, 0, 0, 1, 32'hDEAD_BEE0);
    @(negedge clk); drive(1, 1, 1, 0, 0); #1;
    check("rstflush.pre", 32'(bus.flush_o), 32'h1);
    #1 rst = 1'b0;
    #1;
    outs("rstflush.abort", 6'b000000, 0, 32'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    outs("rstflush.rel", 6'b000000, 0, 32'h0, 0);
    @(negedge clk); #1;
    outs("rstflush.after", 6'b000000, 0, 32'h0, 0);
    idle(2);

    // Randomized traffic against a behavioural model
    m_flush  = 1'b0;
    m_pc     = 32'h0;
    m_streak = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      id  = 1'($urandom_range(0, 1));
      ex  = 1'($urandom_range(0, 1));
      mem = ($urandom_range(0, 9) < 8);
      fl  = ($urandom_range(0, 24) == 0);
      pc  = $urandom;
      drive(id, ex, mem, fl, pc);
      #1;
      if (m_flush)  exp_st = 6'b000000;
      else if (fl)  exp_st = 6'b111111;
      else if (mem) exp_st = 6'b011111;
      else if (ex)  exp_st = 6'b001111;
      else if (id)  exp_st = 6'b000111;
      else          exp_st = 6'b000000;
      exp_to = WDOG && !m_flush && !fl && mem && (m_streak + 1 == LIMIT);
      outs($sformatf("rand%0d", c), exp_st, m_flush, m_flush ? m_pc : 32'h0, exp_to);
      if (m_flush) begin
        m_flush  = 1'b0;
        m_streak = 0;
      end else if (fl) begin
        m_flush  = 1'b1;
        m_pc     = pc;
        m_streak = 0;
      end else if (exp_to) begin
        m_flush  = 1'b1;
        m_pc     = TV;
        m_streak = 0;
      end else begin
        m_streak = mem ? m_streak + 1 : 0;
      end
    end

    idle(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 255, is the number of consecutive memory-stall cycles before the watchdog fires (1..255).
REQ-002 Parameter TIMEOUT_VEC, default 32'hBFC0_0380, is the redirect PC used on a watchdog timeout.
REQ-003 clk  in  1  single system clock, all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 stallreq_id  in  1  load-use hazard request from decode.
REQ-006 stallreq_ex  in  1  multi-cycle execute unit busy.
REQ-007 stallreq_mem  in  1  data bus not ready.
REQ-008 flush_req  in  1  exception or redirect request from memory stage.
REQ-009 exc_pc_i  in  32  redirect target accompanying flush_req.
REQ-010 stall_o  out  6 (StallBus)  per-stage hold bits: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = stop.
REQ-011 flush_o  out  1  clear all pipeline registers, one-cycle pulse.
REQ-012 new_pc_o  out  32  redirect PC, valid only while flush_o=1.
REQ-013 timeout_o  out  1  one-cycle pulse when the watchdog fires.

Function
REQ-014 FSM states: RUN and FLUSH; any other encoding SHALL return to RUN on the next edge.
REQ-015 In RUN, stall_o SHALL be combinational from requests with priority flush_req > stallreq_mem > stallreq_ex > stallreq_id.
REQ-016 Encodings: flush_req 6'b111111; mem 6'b011111; ex 6'b001111; id 6'b000111; none 6'b000000.
REQ-017 RUN with flush_req=1 at edge N SHALL latch exc_pc_i and enter FLUSH; in cycle N+1 flush_o=1, new_pc_o=latched value, stall_o=0.
REQ-018 FLUSH SHALL last exactly one cycle, then return to RUN unconditionally; flush_req during FLUSH is ignored.
REQ-019 In FLUSH, stall requests SHALL be ignored and the watchdog count cleared.
REQ-020 Watchdog count increments each RUN cycle with stallreq_mem=1 and flush_req=0; it clears when stallreq_mem=0.
REQ-021 When the count reaches WAIT_LIMIT, timeout_o SHALL pulse in that cycle, the next state SHALL be FLUSH with new_pc_o=TIMEOUT_VEC, and the count SHALL clear.
REQ-022 If flush_req and watchdog expiry coincide, flush_req wins: redirect to exc_pc_i, and timeout_o stays 0.
REQ-023 The count SHALL be 8 bits and never wrap: it saturates at WAIT_LIMIT.
REQ-024 Outside FLUSH, new_pc_o SHALL be 32'h0.

Reset
REQ-025 On rst=0, immediately (asynchronously): state RUN, count 0, latched PC 0, flush_o=0, timeout_o=0, new_pc_o=0.
REQ-026 During reset, stall_o SHALL be 6'b000000 regardless of requests.
REQ-027 Reset asserted during FLUSH SHALL abort the flush pulse in the same cycle.

Configuration
REQ-028 Macro PIPE_CTRL_WDOG_EN defined: the watchdog of REQ-020..023 is present.
REQ-029 Macro PIPE_CTRL_WDOG_EN undefined: no counter is built, timeout_o is tied 0, and stallreq_mem may hold indefinitely.

Structure
REQ-030 Shared Defines SHALL hold StallBus width, the four stall encodings, the state encodings, Stop/NotStop, and the TIMEOUT_VEC default.
REQ-031 The watchdog SHALL be a sub-module pipe_ctrl_wdog (inputs: clk, rst, inc, clr; outputs: expire), instantiated only under PIPE_CTRL_WDOG_EN.

Verification
REQ-032 stallreq_id=1, then stallreq_ex=1 added, then stallreq_mem=1 added -> stall_o 000111, then 001111, then 011111, each in the same cycle.
REQ-033 flush_req=1 with exc_pc_i=32'h8000_0180 for 1 cycle -> stall_o=111111 that cycle; next cycle flush_o=1, new_pc_o=32'h8000_0180, stall_o=0; following cycle flush_o=0.
REQ-034 WAIT_LIMIT=4, stallreq_mem held -> timeout_o pulse on the 4th cycle; next cycle flush_o=1 with new_pc_o=TIMEOUT_VEC.
REQ-035 WAIT_LIMIT=4, stallreq_mem held 3 cycles, dropped 1 cycle, held 3 cycles -> no timeout_o.
REQ-036 flush_req coinciding with watchdog expiry -> new_pc_o=exc_pc_i, timeout_o=0; rst pulled low mid-FLUSH -> all outputs 0 immediately.
